creek_ctrl_regs: RTL and testbench

- Parametrised Avalon-MM control/status register block for NUM_CORES creek cores.
- Per core it provides:
  - a pause_n level;
  - a resume pulse of programmable length;
  - a synchronised waiting status;
  - a sticky waiting-rise event with interrupt generation.
- Sits between the HPS/Avalon interconnect and the core array. It replaces the single-core 8-bit control adapter.

---
 rtl/creek_ctrl_regs.sv | 138 +++++++++++++
 tb/tb_creek_ctrl_regs.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/creek_ctrl_regs.sv
// rtl/creek_ctrl_regs.sv - Avalon-MM control/status registers for an array of creek cores
//
// Per core: a pause_n run level, a resume pulse of RESUME_CYCLES clocks,
// a synchronised waiting status and a sticky waiting-rise event that can
// raise a level interrupt.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   avl_address   word address (0 CTRL, 1 RESUME, 2 STATUS, 3 EVENT, 4 IRQ_EN, 5 INFO)
//   avl_writedata write data
//   avl_write     write strobe
//   avl_read      read strobe
//   avl_readdata  read data, valid the cycle after avl_read, held otherwise
//   pause_n       per-core run enable (0 = paused)
//   resume        per-core resume pulse
//   waiting       per-core waiting flag, may be asynchronous to clk
//   irq           level interrupt, |(EVENT & IRQ_EN) registered

module creek_ctrl_regs #(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned RESUME_CYCLES = 1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  VERSION       = 8'h02
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avl_address,
    input  logic [31:0]          avl_writedata,
    input  logic                 avl_write,
    input  logic                 avl_read,
    output logic [31:0]          avl_readdata,
    output logic [NUM_CORES-1:0] pause_n,
    output logic [NUM_CORES-1:0] resume,
    input  logic [NUM_CORES-1:0] waiting,
    output logic                 irq
);

    localparam int unsigned CW        = $clog2(RESUME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESUME_CYCLES);
    localparam logic [7:0]  NCORES8   = 8'(NUM_CORES);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_RESUME = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_EVENT  = 3'd3;
    localparam logic [2:0] A_IRQEN  = 3'd4;
    localparam logic [2:0] A_INFO   = 3'd5;

    logic [NUM_CORES-1:0]                  ctrl_q;
    logic [NUM_CORES-1:0]                  event_q;
    logic [NUM_CORES-1:0]                  irq_en_q;
    logic [NUM_CORES-1:0]                  prev_q;
    logic [SYNC_STAGES-1:0][NUM_CORES-1:0] sync_q;
    logic [CW-1:0]                         cnt_q [NUM_CORES];

    logic [NUM_CORES-1:0] wdata;
    logic [NUM_CORES-1:0] sync_w;
    logic [NUM_CORES-1:0] rise;
    logic [NUM_CORES-1:0] ev_clr;
    logic [31:0]          rdata;
    logic                 wr_ctrl, wr_resume, wr_event, wr_irqen;
    logic                 unused_wdata;

    // Upper write-data bits beyond the core count are deliberately ignored.
    assign unused_wdata = ^avl_writedata;
    assign wdata        = avl_writedata[NUM_CORES-1:0];

    assign wr_ctrl   = avl_write && (avl_address == A_CTRL);
    assign wr_resume = avl_write && (avl_address == A_RESUME);
    assign wr_event  = avl_write && (avl_address == A_EVENT);
    assign wr_irqen  = avl_write && (avl_address == A_IRQEN);

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign rise   = sync_w & ~prev_q;
    assign ev_clr = wr_event ? wdata : '0;

    assign pause_n = ctrl_q;

    always_comb begin
        rdata = 32'd0;
        case (avl_address)
            A_CTRL:   rdata = 32'(ctrl_q);
            A_RESUME: rdata = 32'(resume);
            A_STATUS: rdata = 32'(sync_w);
            A_EVENT:  rdata = 32'(event_q);
            A_IRQEN:  rdata = 32'(irq_en_q);
            A_INFO:   rdata = {16'd0, NCORES8, VERSION};
            default:  rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q       <= '0;
            event_q      <= '0;
            irq_en_q     <= '0;
            prev_q       <= '0;
            sync_q       <= '0;
            resume       <= '0;
            irq          <= 1'b0;
            avl_readdata <= 32'd0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl)  ctrl_q   <= wdata;
            if (wr_irqen) irq_en_q <= wdata;

            sync_q[0] <= waiting;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_w;

            // A rise in the same cycle as a clear keeps the event set.
            event_q <= (event_q & ~ev_clr) | rise;

            // Uses the pre-edge EVENT/IRQ_EN, so irq lags them by one cycle.
            irq <= |(event_q & irq_en_q);

            // resume follows the pre-edge counter: it rises the cycle after the
            // load and stays high for exactly RESUME_CYCLES cycles. A reload
            // while busy extends the pulse without a gap.
            for (int i = 0; i < NUM_CORES; i++) begin
                resume[i] <= (cnt_q[i] != '0);
                if (wr_resume && wdata[i]) begin
                    cnt_q[i] <= CNT_LOAD;
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end

            if (avl_read) avl_readdata <= rdata;
        end
    end

endmodule

// File: tb/tb_creek_ctrl_regs.sv
// tb/tb_creek_ctrl_regs.sv - scoreboard bench for creek_ctrl_regs

module tb_creek_ctrl_regs;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    avl_address = '0;
    logic [31:0]   avl_writedata = '0;
    logic          avl_write = 1'b0;
    logic          avl_read = 1'b0;
    logic [31:0]   avl_readdata;
    logic [NC-1:0] pause_n;
    logic [NC-1:0] resume;
    logic [NC-1:0] waiting = '0;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] exp;
        int          addr;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    creek_ctrl_regs #(
        .NUM_CORES(NC),
        .RESUME_CYCLES(3),
        .SYNC_STAGES(2),
        .VERSION(8'h02)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avl_address(avl_address),
        .avl_writedata(avl_writedata),
        .avl_write(avl_write),
        .avl_read(avl_read),
        .avl_readdata(avl_readdata),
        .pause_n(pause_n),
        .resume(resume),
        .waiting(waiting),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a read strobe seen at an edge means avl_readdata is valid just after it.
    always @(posedge clk) begin
        if (avl_read && reset_n) begin
            #1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: got 0x%08h expected none", avl_readdata);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                if (avl_readdata !== e.exp) begin
                    n_fail++;
                    $display("FAIL read_addr%0d: got 0x%08h expected 0x%08h at %0t",
                             e.addr, avl_readdata, e.exp, $time);
                end
            end
        end
    end

    // All drive tasks start at a negedge and return at the following negedge.
    task automatic wr(input int addr, input logic [31:0] data);
        avl_address   = 3'(addr);
        avl_writedata = data;
        avl_write     = 1'b1;
        @(negedge clk);
        avl_write     = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [31:0] exp);
        rd_exp_t e;
        e.exp  = exp;
        e.addr = addr;
        exp_q.push_back(e);
        avl_address = 3'(addr);
        avl_read    = 1'b1;
        @(negedge clk);
        avl_read    = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1. reset state
        step(3);
        chk("rst_pause_n", 32'(pause_n), 0);
        chk("rst_resume", 32'(resume), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_readdata", avl_readdata, 0);
        reset_n = 1'b1;
        step(1);
        for (int a = 0; a < 8; a++) begin
            rd(a, (a == 5) ? 32'h0000_0402 : 32'h0);
        end

        // 2. CTRL
        wr(0, 32'h5);
        chk("ctrl_pause_n", 32'(pause_n), 32'h5);
        rd(0, 32'h5);
        wr(0, 32'hFFFF_FFFF);
        chk("ctrl_pause_n_all", 32'(pause_n), 32'hF);
        rd(0, 32'hF);
        wr(0, 32'h0);

        // 3. resume pulse of 3 cycles, then extended to 5
        wr(1, 32'h2);
        chk("res_after_write", 32'(resume), 0);
        step(1);
        chk("res_c1", 32'(resume), 32'h2);
        rd(1, 32'h2);
        chk("res_c2", 32'(resume), 32'h2);
        step(1);
        chk("res_c3", 32'(resume), 32'h2);
        step(1);
        chk("res_end", 32'(resume), 0);

        wr(1, 32'h2);
        chk("ext_after_write", 32'(resume), 0);
        step(1);
        chk("ext_c1", 32'(resume), 32'h2);
        wr(1, 32'h2);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("ext_c%0d", k), 32'(resume), 32'h2);
            step(1);
        end
        chk("ext_end", 32'(resume), 0);

        // 4. waiting[3] rises asynchronously
        #2 waiting = 4'h8;
        step(2);
        rd(2, 32'h8);
        rd(3, 32'h8);

        // 5. interrupt enable, clear, and set-vs-clear collision
        wr(4, 32'h8);
        chk("irq_before", 32'(irq), 0);
        step(1);
        chk("irq_rise", 32'(irq), 1);
        wr(3, 32'h8);
        chk("irq_hold_after_clr", 32'(irq), 1);
        step(1);
        chk("irq_fall", 32'(irq), 0);
        step(3);
        rd(3, 32'h0);

        #2 waiting = 4'h0;
        step(4);
        #2 waiting = 4'h8;
        step(4);
        #2 waiting = 4'h0;
        step(4);
        chk("irq_second_event", 32'(irq), 1);
        #2 waiting = 4'h8;
        step(2);
        wr(3, 32'h8);
        chk("irq_collide_0", 32'(irq), 1);
        step(1);
        chk("irq_collide_1", 32'(irq), 1);
        rd(3, 32'h8);

        // 6. asynchronous reset mid-pulse
        wr(0, 32'hF);
        wr(1, 32'h1);
        step(1);
        chk("pre_rst_resume", 32'(resume), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_resume", 32'(resume), 0);
        chk("arst_pause_n", 32'(pause_n), 0);
        chk("arst_irq", 32'(irq), 0);
        waiting = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
        for (int a = 0; a < 8; a++) begin
            rd(a, (a == 5) ? 32'h0000_0402 : 32'h0);
        end
        chk("post_rst_pause_n", 32'(pause_n), 0);
        chk("post_rst_irq", 32'(irq), 0);

        step(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
